// File: rtl/design_exmpl_param_rtl.sv
// Start/count/flag control datapath. A loaded counter steps up or down once per clock and
// samples one bit into E. When the pre-step value matches STOP_MASK it passes through FLAG, which sets F.
module design_exmpl_param_rtl #(
    parameter int               WIDTH     = 4,
    parameter int               E_BIT     = 2,
    parameter logic [WIDTH-1:0] STOP_MASK = WIDTH'(4'b1100)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             dir_i,
    input  logic [WIDTH-1:0] init_i,
    output logic [WIDTH-1:0] A_o,
    output logic             E_o,
    output logic             F_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH:0]   cycles_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        FLAG  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             e_q, e_d;
    logic             f_q, f_d;
    logic             dir_q, dir_d;
    logic             done_q, done_d;
    logic [WIDTH:0]   cycles_q, cycles_d;
    logic             stop_hit;

    // The stop test uses the value before this cycle's step.
    assign stop_hit = (a_q & STOP_MASK) == STOP_MASK;

    always_comb begin
        // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
        state_d  = state_q;
        a_d      = a_q;
        e_d      = e_q;
        f_d      = f_q;
        dir_d    = dir_q;
        cycles_d = cycles_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    a_d      = init_i;
                    f_d      = 1'b0;
                    cycles_d = '0;
                    dir_d    = dir_i;
                    state_d  = COUNT;
                end
            end
            COUNT: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    a_d      = dir_q ? a_q - 1'b1 : a_q + 1'b1;
                    e_d      = a_q[E_BIT];
                    cycles_d = cycles_q + 1'b1;
                    if (stop_hit) begin
                        state_d = FLAG;
                    end
                end
            end
            FLAG: begin
                f_d     = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments here, so every register updates from the same pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            a_q      <= '0;
            e_q      <= 1'b0;
            f_q      <= 1'b0;
            dir_q    <= 1'b0;
            done_q   <= 1'b0;
            cycles_q <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            e_q      <= e_d;
            f_q      <= f_d;
            dir_q    <= dir_d;
            done_q   <= done_d;
            cycles_q <= cycles_d;
        end
    end

    assign A_o      = a_q;
    assign E_o      = e_q;
    assign F_o      = f_q;
    assign busy_o   = (state_q != IDLE);
    assign done_o   = done_q;
    assign cycles_o = cycles_q;

endmodule

// File: tb/tb_design_exmpl_param_rtl.sv
// Scoreboard bench for design_exmpl_param_rtl. A default 4-bit instance and an 8-bit instance are
// run from one sequence. Expected run results are queued at start and popped on done.
module tb_design_exmpl_param_rtl;

    typedef struct packed {
        logic [7:0] a;
        logic       e;
        logic       f;
        logic [8:0] cycles;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       start4 = 1'b0, abort4 = 1'b0, dir4 = 1'b0;
    logic [3:0] init4 = '0;
    logic [3:0] a4;
    logic       e4, f4, busy4, done4;
    logic [4:0] cyc4;

    logic       start8 = 1'b0, abort8 = 1'b0, dir8 = 1'b0;
    logic [7:0] init8 = '0;
    logic [7:0] a8;
    logic       e8, f8, busy8, done8;
    logic [8:0] cyc8;

    logic       sel8 = 1'b0;
    logic [7:0] mon_a;
    logic [8:0] mon_cyc;
    logic       mon_e, mon_f, mon_busy, mon_done;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    design_exmpl_param_rtl dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start4), .abort_i(abort4), .dir_i(dir4),
        .init_i(init4), .A_o(a4), .E_o(e4), .F_o(f4), .busy_o(busy4), .done_o(done4),
        .cycles_o(cyc4)
    );

    design_exmpl_param_rtl #(.WIDTH(8), .E_BIT(7), .STOP_MASK(8'hF0)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start8), .abort_i(abort8), .dir_i(dir8),
        .init_i(init8), .A_o(a8), .E_o(e8), .F_o(f8), .busy_o(busy8), .done_o(done8),
        .cycles_o(cyc8)
    );

    assign mon_a    = sel8 ? a8 : {4'b0, a4};
    assign mon_cyc  = sel8 ? cyc8 : {4'b0, cyc4};
    assign mon_e    = sel8 ? e8 : e4;
    assign mon_f    = sel8 ? f8 : f4;
    assign mon_busy = sel8 ? busy8 : busy4;
    assign mon_done = sel8 ? done8 : done4;

    // Reference run of the default instance: stop mask 1100, E taken from bit 2.
    function automatic exp_t model4(input logic [3:0] init, input logic dir);
        exp_t       r;
        logic [3:0] a;
        logic       hit;
        r = '0;
        a = init;
        for (int i = 0; i < 16; i++) begin
            hit      = (a & 4'b1100) == 4'b1100;
            r.e      = a[2];
            a        = dir ? a - 4'd1 : a + 4'd1;
            r.cycles = r.cycles + 9'd1;
            if (hit) break;
        end
        r.a = {4'b0, a};
        r.f = 1'b1;
        return r;
    endfunction

    function automatic exp_t mk(input logic [7:0] a, input logic e, input logic [8:0] c);
        exp_t r;
        r.a = a; r.e = e; r.f = 1'b1; r.cycles = c;
        return r;
    endfunction

    task automatic start_run(input bit s8, input logic [7:0] init, input logic d);
        if (s8) begin
            init8 = init; dir8 = d; start8 = 1'b1;
        end else begin
            init4 = init[3:0]; dir4 = d; start4 = 1'b1;
        end
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
    endtask

    // Waits at negedges for done, counting busy cycles. Returns while still in the done cycle.
    task automatic wait_done(input int budget, input bit scramble, output int busy_cnt);
        bit   seen;
        exp_t x;
        seen     = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            if (mon_busy) busy_cnt++;
            if (mon_done) begin
                seen = 1'b1;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected: done_o=1 with no run expected");
                end else begin
                    x = sb.pop_front();
                    if (mon_a !== x.a || mon_e !== x.e || mon_f !== x.f || mon_cyc !== x.cycles) begin
                        errors++;
                        $display("FAIL run_result: got A=%h E=%b F=%b cycles=%0d, want A=%h E=%b F=%b cycles=%0d",
                                 mon_a, mon_e, mon_f, mon_cyc, x.a, x.e, x.f, x.cycles);
                    end
                end
            end else begin
                if (scramble) begin
                    init4 = 4'($urandom); dir4 = 1'($urandom);
                    init8 = 8'($urandom); dir8 = 1'($urandom);
                end
                @(negedge clk);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: no done_o within %0d cycles", budget);
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({a4, e4, f4, busy4, done4, cyc4} !== '0) begin
            errors++;
            $display("FAIL reset4: got A=%h E=%b F=%b busy=%b done=%b cycles=%0d, want all 0",
                     a4, e4, f4, busy4, done4, cyc4);
        end
        checks++;
        if ({a8, e8, f8, busy8, done8, cyc8} !== '0) begin
            errors++;
            $display("FAIL reset8: got A=%h busy=%b cycles=%0d, want all 0", a8, busy8, cyc8);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy4 !== 1'b0 || done4 !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy4, done4);
        end
    endtask

    task automatic test_count_up();
        int bc;
        sb.push_back(mk(8'h0D, 1'b1, 9'd13));
        start_run(1'b0, 8'h00, 1'b0);
        wait_done(40, 1'b1, bc);
        checks++;
        if (bc !== 14) begin
            errors++;
            $display("FAIL busy_len: got %0d busy cycles, want 14", bc);
        end
        @(negedge clk);
        checks++;
        if (done4 !== 1'b0 || f4 !== 1'b1 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse: got done=%b F=%b busy=%b, want 0 1 0", done4, f4, busy4);
        end
    endtask

    task automatic test_count_down();
        int bc;
        sb.push_back(mk(8'h0E, 1'b1, 9'd2));
        start_run(1'b0, 8'h00, 1'b1);
        wait_done(40, 1'b1, bc);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int bc;
        sb.push_back(mk(8'h0D, 1'b1, 9'd1));
        init4  = 4'hC;
        dir4   = 1'b0;
        start4 = 1'b1;
        @(negedge clk);
        wait_done(40, 1'b0, bc);
        sb.push_back(mk(8'h0D, 1'b1, 9'd1));
        @(negedge clk);
        start4 = 1'b0;
        checks++;
        if (busy4 !== 1'b1 || f4 !== 1'b0 || a4 !== 4'hC || cyc4 !== 5'd0) begin
            errors++;
            $display("FAIL b2b_restart: got busy=%b F=%b A=%h cycles=%0d, want 1 0 c 0",
                     busy4, f4, a4, cyc4);
        end
        wait_done(40, 1'b1, bc);
        @(negedge clk);
    endtask

    task automatic test_abort();
        start_run(1'b0, 8'h00, 1'b0);
        repeat (4) @(negedge clk);
        abort4 = 1'b1;
        @(negedge clk);
        abort4 = 1'b0;
        checks++;
        if (busy4 !== 1'b0 || a4 !== 4'h4 || cyc4 !== 5'd4 || f4 !== 1'b0 || done4 !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: got busy=%b A=%h cycles=%0d F=%b done=%b, want 0 4 4 0 0",
                     busy4, a4, cyc4, f4, done4);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (done4 !== 1'b0 || busy4 !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet: got done=%b busy=%b, want 0 0", done4, busy4);
            end
        end
        // Abort on a step that would also match the stop mask.
        start_run(1'b0, 8'h0C, 1'b0);
        abort4 = 1'b1;
        @(negedge clk);
        abort4 = 1'b0;
        checks++;
        if (busy4 !== 1'b0 || a4 !== 4'hC || cyc4 !== 5'd0 || f4 !== 1'b0) begin
            errors++;
            $display("FAIL abort_priority: got busy=%b A=%h cycles=%0d F=%b, want 0 c 0 0",
                     busy4, a4, cyc4, f4);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done4 !== 1'b0 || f4 !== 1'b0) begin
            errors++;
            $display("FAIL abort_priority_quiet: got done=%b F=%b, want 0 0", done4, f4);
        end
    endtask

    task automatic test_midrun_reset();
        bit seen_done;
        start_run(1'b0, 8'h00, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({a4, e4, f4, busy4, done4, cyc4} !== '0) begin
            errors++;
            $display("FAIL midrun_reset: got A=%h E=%b F=%b busy=%b done=%b cycles=%0d, want all 0",
                     a4, e4, f4, busy4, done4, cyc4);
        end
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (done4 || busy4) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            errors++;
            $display("FAIL midrun_after: got activity after reset, want idle with no done");
        end
    endtask

    task automatic test_random();
        int         bc;
        logic [3:0] ri;
        logic       rd;
        for (int n = 0; n < 8; n++) begin
            ri = 4'($urandom_range(15));
            rd = 1'($urandom_range(1));
            sb.push_back(model4(ri, rd));
            start_run(1'b0, {4'b0, ri}, rd);
            wait_done(40, 1'b1, bc);
        end
        @(negedge clk);
    endtask

    task automatic test_width8();
        int bc;
        sel8 = 1'b1;
        sb.push_back(mk(8'hF1, 1'b1, 9'd17));
        start_run(1'b1, 8'hE0, 1'b0);
        wait_done(60, 1'b1, bc);
        checks++;
        if (bc !== 18) begin
            errors++;
            $display("FAIL w8_busy: got %0d busy cycles, want 18", bc);
        end
        @(negedge clk);
        sel8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_back_to_back();
        test_abort();
        test_midrun_reset();
        test_random();
        test_width8();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending runs, want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
